// File: rtl/ecc_pkg.sv
// ============================================================================
// ecc_pkg : shared types and constants for the ECC inverse datapath
// Revision: 1.0
// ============================================================================
`default_nettype none

package ecc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } inv_state_t;

    // Cycles RUN may last before the engine gives up on an operand pair.
    function automatic int timeout_limit(input int width);
        return 2 * width + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_half.sv
// ============================================================================
// mod_half : x/2 mod p for odd p, adding p first when x is odd
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_half #(
    parameter int n = 231
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] p,
    output logic [n-1:0] half
);

    logic [n:0] sum;

    // x odd and p odd make x+p even; the extra top bit absorbs the carry.
    assign sum  = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
    assign half = sum[n:1];

endmodule

`default_nettype wire

// File: rtl/modular_inverse_euclid.sv
// ============================================================================
// modular_inverse_euclid : X = A^-1 mod p by binary extended Euclid, one step
// per clock. Optional macro INV_TIMEOUT_EN adds a RUN iteration timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module modular_inverse_euclid
    import ecc_pkg::*;
#(
    parameter int n = 231
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] p,
    input  logic [n-1:0] A,
    output logic [n-1:0] X,
    output logic         result_ready,
    output logic         busy,
    output logic         error
);

    localparam logic [n-1:0] ONE = n'(1);

    inv_state_t   state;
    logic [n-1:0] u;
    logic [n-1:0] v;
    logic [n-1:0] x1;
    logic [n-1:0] x2;
    logic [n-1:0] pr;
    logic         fin;
    logic         fin_err;

    logic [n-1:0] x1_half;
    logic [n-1:0] x2_half;
    logic [n-1:0] x1_sub;
    logic [n-1:0] x2_sub;

`ifdef INV_TIMEOUT_EN
    localparam int LIMIT = timeout_limit(n);
    localparam int CW    = $clog2(LIMIT);
    logic [CW-1:0] cnt;
`endif

    function automatic logic [n-1:0] mod_sub(input logic [n-1:0] a,
                                             input logic [n-1:0] b,
                                             input logic [n-1:0] m);
        logic [n:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) begin
            d = d + {1'b0, m};
        end
        return d[n-1:0];
    endfunction

    mod_half #(.n(n)) half_x1_i (.x(x1), .p(pr), .half(x1_half));
    mod_half #(.n(n)) half_x2_i (.x(x2), .p(pr), .half(x2_half));

    assign x1_sub = mod_sub(x1, x2, pr);
    assign x2_sub = mod_sub(x2, x1, pr);

    // A terminating check only records the result; the following edge moves
    // to DONE, so outputs appear two edges after the last reduction step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            u            <= '0;
            v            <= '0;
            x1           <= '0;
            x2           <= '0;
            pr           <= '0;
            fin          <= 1'b0;
            fin_err      <= 1'b0;
            X            <= '0;
            result_ready <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
`ifdef INV_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        u            <= A;
                        v            <= p;
                        x1           <= ONE;
                        x2           <= '0;
                        pr           <= p;
                        fin          <= 1'b0;
                        fin_err      <= 1'b0;
                        result_ready <= 1'b0;
                        error        <= 1'b0;
                        busy         <= 1'b1;
                        state        <= RUN;
`ifdef INV_TIMEOUT_EN
                        cnt          <= '0;
`endif
                    end
                end
                RUN: begin
                    if (fin) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_ready <= 1'b1;
                        error        <= fin_err;
                    end else begin
`ifdef INV_TIMEOUT_EN
                        cnt <= cnt + CW'(1);
`endif
                        if (u == '0) begin
                            X       <= '0;
                            fin_err <= 1'b1;
                            fin     <= 1'b1;
                        end else if (u == ONE) begin
                            X   <= x1;
                            fin <= 1'b1;
                        end else if (v == ONE) begin
                            X   <= x2;
                            fin <= 1'b1;
`ifdef INV_TIMEOUT_EN
                        end else if (cnt == CW'(LIMIT - 2)) begin
                            X       <= '0;
                            fin_err <= 1'b1;
                            fin     <= 1'b1;
`endif
                        end else if (!u[0]) begin
                            u  <= u >> 1;
                            x1 <= x1_half;
                        end else if (!v[0]) begin
                            v  <= v >> 1;
                            x2 <= x2_half;
                        end else if (u >= v) begin
                            u  <= u - v;
                            x1 <= x1_sub;
                        end else begin
                            v  <= v - u;
                            x2 <= x2_sub;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
